heartbeat_gen: RTL and testbench
================================

Name: heartbeat_gen

Overview:
- Drives a status LED with a "lub-dub" heartbeat brightness pattern via PWM.
- An envelope FSM ramps a brightness value in two pulses (large "lub", smaller "dub"), followed by a rest period.
- A free-running 8-bit PWM stage converts that brightness to a single-bit output.
- Sits at board top level; needs only the system clock (100 MHz nominal) and reset.

Parameters:
- STEP_DIV, 100000, clocks per envelope tick (1 ms at 100 MHz); must be >= 2.
- RAMP_STEP, 16, brightness change per tick during ramps (1..255).
- LUB_PEAK, 255, peak brightness of first pulse (1..255).
- DUB_PEAK, 128, peak brightness of second pulse (1..255).
- GAP_TICKS, 100, ticks between lub end and dub start (>= 1).
- REST_TICKS, 600, ticks between dub end and next lub start (>= 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; low = reset asserted.
- pwm  output  1  registered PWM LED drive, high = LED on.

Behaviour:
- Reset (reset low, asynchronous) sets:
  - prescaler = 0, tick counter = 0, brightness = 0;
  - state = LUB_UP, pwm_cnt = 0, duty_q = 0, pwm = 0.
- Reset release is synchronous to clk.
- Prescaler:
  - counts 0..STEP_DIV-1, then wraps;
  - a one-cycle tick is asserted when the count = STEP_DIV-1, so the first tick falls on the STEP_DIV-th clock after reset release.
- Envelope FSM advances only on tick. Brightness is 8 bits, unsigned.
  - LUB_UP: brightness = min(brightness+RAMP_STEP, LUB_PEAK), using a 9-bit sum with no wrap. When the result equals LUB_PEAK, go to LUB_DOWN.
  - LUB_DOWN: brightness = max(brightness-RAMP_STEP, 0), with no underflow. When the result is 0, go to GAP and clear the tick counter.
  - GAP: increment the tick counter. When it reaches GAP_TICKS, go to DUB_UP and clear the counter.
  - DUB_UP: as LUB_UP, but saturating at DUB_PEAK; then go to DUB_DOWN.
  - DUB_DOWN: as LUB_DOWN; at 0 go to REST and clear the counter.
  - REST: count REST_TICKS ticks, then go to LUB_UP.
  - Illegal state encoding: recover to LUB_UP with brightness 0 on the next tick.
- Duty: duty = brightness (see Optional Feature).
- PWM stage:
  - pwm_cnt is 8 bits, free-running, incrementing every clock and wrapping 255 to 0.
  - duty_q loads duty only on the clock where pwm_cnt = 255, so duty changes take effect at a period boundary and never glitch mid-period.
  - pwm is registered: pwm <= (pwm_cnt < duty_q).
  - Duty 0 gives constant low. Duty 255 gives 255 of 256 clocks high.
  - PWM period = 256 clocks.
- Reset asserted mid-pattern: immediate return to the reset values above, with pwm low in the same instant.
- No other outputs and no dependency on input timing beyond clk/reset.

Optional Feature:
- Macro: HEARTBEAT_GAMMA_EN.
- Defined: duty = upper 8 bits of brightness*brightness (16-bit product), for a perceptual gamma of about 2. Example: brightness 128 gives duty 64; 255 gives 254; values below 16 give 0.
- Undefined: duty = brightness (linear).
- The FSM, tick and PWM timing are identical in both builds.

Decomposition:
- Package heartbeat_pkg:
  - state enum: LUB_UP, LUB_DOWN, GAP, DUB_UP, DUB_DOWN, REST;
  - localparam PWM_W = 8;
  - saturating add/subtract functions.
- One natural sub-module, pwm_modulator. It holds pwm_cnt, duty_q and the pwm register. Ports: clk, reset, duty[7:0], pwm.
- heartbeat_gen holds the prescaler, the envelope FSM and the optional gamma stage.

Test Plan (all with STEP_DIV=4, RAMP_STEP=64, GAP_TICKS=2, REST_TICKS=3, LUB_PEAK=255, DUB_PEAK=128, gamma off, 10 ns clock):
- Reset: reset low for 100 ns -> pwm = 0, brightness = 0, state = LUB_UP throughout. Release -> first tick on the 4th clock.
- Envelope sequence: over 17 ticks, brightness at each tick = 64, 128, 192, 255, 191, 127, 63, 0, 0, 0, 64, 128, 64, 0, 0, 0, 0. State returns to LUB_UP after tick 17, and the pattern repeats with a period of 68 clocks.
- PWM duty: hold duty 128 -> exactly 128 high clocks per 256-clock period. Duty 0 -> pwm never high. Duty 255 -> 255 high per period.
- Glitch-free update: change brightness mid-period -> the high-time of the current period is unchanged; the new duty applies starting at pwm_cnt = 0.
- Async reset mid-pattern: assert reset during DUB_UP between clock edges -> pwm falls immediately. After release, the sequence restarts from LUB_UP with brightness 0.
- Gamma build (HEARTBEAT_GAMMA_EN): brightness 128 -> 64 high clocks per period; brightness 255 -> 254.

Source files
------------

// File: rtl/heartbeat_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : heartbeat_pkg
// Purpose  : Shared types, widths and saturating helpers for heartbeat_gen.
// Revision : 1.0 - initial release
// ============================================================================
package heartbeat_pkg;

    localparam int PWM_W = 8;

    typedef enum logic [2:0] {
        LUB_UP   = 3'd0,
        LUB_DOWN = 3'd1,
        GAP      = 3'd2,
        DUB_UP   = 3'd3,
        DUB_DOWN = 3'd4,
        REST     = 3'd5
    } state_t;

    // Sum is formed one bit wider so a large step can never wrap past the limit.
    function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a,
                                                 input logic [PWM_W-1:0] b,
                                                 input logic [PWM_W-1:0] lim);
        logic [PWM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, lim})
            sat_add = lim;
        else
            sat_add = sum[PWM_W-1:0];
    endfunction

    function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a,
                                                 input logic [PWM_W-1:0] b);
        if (a > b)
            sat_sub = a - b;
        else
            sat_sub = '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_modulator
// Purpose  : Free-running 8-bit PWM; duty is latched only at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_modulator
    import heartbeat_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_duty_q;
    logic             r_pwm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt <= '0;
            r_duty_q  <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            // Sampling on the last count keeps the high-time of a period intact.
            if (r_pwm_cnt == '1)
                r_duty_q <= duty;
            r_pwm <= (r_pwm_cnt < r_duty_q);
        end
    end

    assign pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/heartbeat_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : heartbeat_gen
// Purpose  : "Lub-dub" LED heartbeat: prescaler, envelope FSM and PWM output.
//            Define HEARTBEAT_GAMMA_EN for a squared (gamma ~2) duty curve.
// Revision : 1.0 - initial release
// ============================================================================
module heartbeat_gen
    import heartbeat_pkg::*;
#(
    parameter int STEP_DIV   = 100000,
    parameter int RAMP_STEP  = 16,
    parameter int LUB_PEAK   = 255,
    parameter int DUB_PEAK   = 128,
    parameter int GAP_TICKS  = 100,
    parameter int REST_TICKS = 600
) (
    input  logic clk,
    input  logic reset,
    output logic pwm
);

    localparam int c_div_w = $clog2(STEP_DIV);
    localparam int c_cnt_max = (GAP_TICKS > REST_TICKS) ? GAP_TICKS : REST_TICKS;
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);

    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(STEP_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_ticks = c_cnt_w'(GAP_TICKS);
    localparam logic [c_cnt_w-1:0] c_rest_ticks = c_cnt_w'(REST_TICKS);
    localparam logic [PWM_W-1:0]   c_ramp      = PWM_W'(RAMP_STEP);
    localparam logic [PWM_W-1:0]   c_lub_peak  = PWM_W'(LUB_PEAK);
    localparam logic [PWM_W-1:0]   c_dub_peak  = PWM_W'(DUB_PEAK);

    logic [c_div_w-1:0] r_presc;
    logic               w_tick;

    state_t             r_state, w_state_nxt;
    logic [PWM_W-1:0]   r_brightness, w_bright_nxt;
    logic [c_cnt_w-1:0] r_ticks, w_ticks_nxt;
    logic [c_cnt_w-1:0] w_ticks_inc;
    logic [PWM_W-1:0]   w_duty;

    assign w_tick      = (r_presc == c_div_last);
    assign w_ticks_inc = r_ticks + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc      <= '0;
            r_state      <= LUB_UP;
            r_brightness <= '0;
            r_ticks      <= '0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            r_state      <= w_state_nxt;
            r_brightness <= w_bright_nxt;
            r_ticks      <= w_ticks_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bright_nxt = r_brightness;
        w_ticks_nxt  = r_ticks;
        if (w_tick) begin
            case (r_state)
                LUB_UP: begin
                    w_bright_nxt = sat_add(r_brightness, c_ramp, c_lub_peak);
                    if (w_bright_nxt == c_lub_peak)
                        w_state_nxt = LUB_DOWN;
                end
                LUB_DOWN: begin
                    w_bright_nxt = sat_sub(r_brightness, c_ramp);
                    if (w_bright_nxt == '0) begin
                        w_state_nxt = GAP;
                        w_ticks_nxt = '0;
                    end
                end
                GAP: begin
                    if (w_ticks_inc == c_gap_ticks) begin
                        w_state_nxt = DUB_UP;
                        w_ticks_nxt = '0;
                    end else begin
                        w_ticks_nxt = w_ticks_inc;
                    end
                end
                DUB_UP: begin
                    w_bright_nxt = sat_add(r_brightness, c_ramp, c_dub_peak);
                    if (w_bright_nxt == c_dub_peak)
                        w_state_nxt = DUB_DOWN;
                end
                DUB_DOWN: begin
                    w_bright_nxt = sat_sub(r_brightness, c_ramp);
                    if (w_bright_nxt == '0) begin
                        w_state_nxt = REST;
                        w_ticks_nxt = '0;
                    end
                end
                REST: begin
                    if (w_ticks_inc == c_rest_ticks) begin
                        w_state_nxt = LUB_UP;
                        w_ticks_nxt = '0;
                    end else begin
                        w_ticks_nxt = w_ticks_inc;
                    end
                end
                default: begin
                    w_state_nxt  = LUB_UP;
                    w_bright_nxt = '0;
                    w_ticks_nxt  = '0;
                end
            endcase
        end
    end

`ifdef HEARTBEAT_GAMMA_EN
    // Upper byte of brightness squared; zero-extended so the product is 16 bits.
    assign w_duty = PWM_W'(({{PWM_W{1'b0}}, r_brightness} *
                            {{PWM_W{1'b0}}, r_brightness}) >> PWM_W);
`else
    assign w_duty = r_brightness;
`endif

    pwm_modulator u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (w_duty),
        .pwm   (pwm)
    );

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_heartbeat_gen
// Purpose  : Self-checking bench for heartbeat_gen with random reset points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heartbeat_gen;
    import heartbeat_pkg::*;

    localparam int STEP_DIV   = 4;
    localparam int RAMP_STEP  = 64;
    localparam int LUB_PEAK   = 255;
    localparam int DUB_PEAK   = 128;
    localparam int GAP_TICKS  = 2;
    localparam int REST_TICKS = 3;
    localparam int PAT_LEN    = 17;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic pwm;

    int n_checks = 0;
    int n_bad    = 0;

    // Brightness after each envelope tick of one full heartbeat.
    int pat [PAT_LEN] = '{64, 128, 192, 255, 191, 127, 63, 0, 0, 0,
                          64, 128, 64, 0, 0, 0, 0};

    heartbeat_gen #(
        .STEP_DIV   (STEP_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .LUB_PEAK   (LUB_PEAK),
        .DUB_PEAK   (DUB_PEAK),
        .GAP_TICKS  (GAP_TICKS),
        .REST_TICKS (REST_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pwm   (pwm)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Brightness after clock edge n counted from reset release.
    function automatic int bright_after(input int n);
        if (n < STEP_DIV)
            return 0;
        return pat[((n / STEP_DIV) - 1) % PAT_LEN];
    endfunction

    function automatic int duty_of(input int b);
`ifdef HEARTBEAT_GAMMA_EN
        return (b * b) / 256;
`else
        return b;
`endif
    endfunction

    // Duty in force during PWM period m (edges 256m+1 .. 256m+256).
    function automatic int period_duty(input int m);
        if (m == 0)
            return 0;
        return duty_of(bright_after(256 * m - 1));
    endfunction

    function automatic int pwm_after(input int n);
        return (((n - 1) % 256) < period_duty((n - 1) / 256)) ? 1 : 0;
    endfunction

    task automatic run_edges(input int nedges);
        int hi = 0;
        for (int n = 1; n <= nedges; n++) begin
            @(posedge clk);
            #1;
            check_val("pwm", pwm, pwm_after(n));
            check_val("brightness", dut.r_brightness, bright_after(n));
            if (pwm)
                hi++;
            if ((n - 1) % 256 == 255) begin
                check_val("period_high", hi, period_duty((n - 1) / 256));
                hi = 0;
            end
            if (n % (PAT_LEN * STEP_DIV) == 0)
                check_val("state_wrap", dut.r_state, LUB_UP);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pwm"}, pwm, 0);
        check_val({tag, "_brightness"}, dut.r_brightness, 0);
        check_val({tag, "_state"}, dut.r_state, LUB_UP);
    endtask

    // Assert reset between edges, confirm the immediate return, then release on a falling edge.
    task automatic async_reset(input int dly);
        #(dly);
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check_reset_vals("held_rst");
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_reset_vals("por");
        end
        reset = 1'b1;

        // Edge 856 sits in DUB_UP during a full-duty period, so pwm is high there.
        run_edges(856);
        #2;
        check_val("dub_up_state", dut.r_state, DUB_UP);
        check_val("pwm_pre_rst", pwm, pwm_after(856));
        async_reset(0);

        for (int k = 0; k < 3; k++) begin
            run_edges($urandom_range(200, 900));
            async_reset($urandom_range(1, 8));
        end

        run_edges(1100);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
